// File: rtl/para_mux_rr.sv
// Parameterised N:1 channel mux with a one-word output register, manual or round-robin selection.
// Optional transfer counter output ocnt is enabled by defining PARA_MUX_CNT_EN.
module para_mux_rr #(
    parameter int NCH = 4,
    parameter int DW  = 3,
    localparam int SW = $clog2(NCH)
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              imode,
    input  logic [SW-1:0]     ia,
    input  logic [NCH*DW-1:0] idata,
    input  logic [NCH-1:0]    ivalid,
    output logic [NCH-1:0]    oready,
    output logic [DW-1:0]     oout,
    output logic [SW-1:0]     osel,
`ifdef PARA_MUX_CNT_EN
    output logic [15:0]       ocnt,
`endif
    output logic              ovalid,
    input  logic              iready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   oout_q, oout_d;
    logic [SW-1:0]   osel_q, osel_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic            slot_free_s;
    logic            man_vld_s, rr_vld_s, cand_vld_s, grant_s;
    logic [SW-1:0]   man_idx_s, rr_idx_s, cand_idx_s;
    logic [DW-1:0]   cand_data_s;
    logic [NCH-1:0]  oready_s;
    int              best_dist_s;
    int              dist_s;

    // Candidate search: manual index check and round-robin nearest-from-pointer search.
    always_comb begin
        man_vld_s   = 1'b0;
        man_idx_s   = {SW{1'b0}};
        rr_vld_s    = 1'b0;
        rr_idx_s    = {SW{1'b0}};
        best_dist_s = NCH;
        dist_s      = 0;
        for (int k = 0; k < NCH; k++) begin
            if (ia == k[SW-1:0] && ivalid[k]) begin
                man_vld_s = 1'b1;
                man_idx_s = k[SW-1:0];
            end else begin
                man_vld_s = man_vld_s;
            end
            // Distance from the pointer going upward with wrap; smallest distance wins.
            dist_s = k - int'(ptr_q);
            if (dist_s < 0) begin
                dist_s = dist_s + NCH;
            end else begin
                dist_s = dist_s;
            end
            if (ivalid[k] && dist_s < best_dist_s) begin
                best_dist_s = dist_s;
                rr_vld_s    = 1'b1;
                rr_idx_s    = k[SW-1:0];
            end else begin
                rr_vld_s    = rr_vld_s;
            end
        end
        if (imode) begin
            cand_vld_s = rr_vld_s;
            cand_idx_s = rr_idx_s;
        end else begin
            cand_vld_s = man_vld_s;
            cand_idx_s = man_idx_s;
        end
    end

    // Grant decision, per-channel accept and next-state computation.
    always_comb begin
        slot_free_s = (state_q == EMPTY) || iready;
        grant_s     = irst_n && slot_free_s && cand_vld_s;
        oready_s    = {NCH{1'b0}};
        cand_data_s = {DW{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            if (grant_s && cand_idx_s == k[SW-1:0]) begin
                oready_s[k] = 1'b1;
                cand_data_s = idata[k*DW +: DW];
            end else begin
                oready_s[k] = 1'b0;
            end
        end
        state_d = state_q;
        oout_d  = oout_q;
        osel_d  = osel_q;
        ptr_d   = ptr_q;
        if (grant_s) begin
            state_d = FULL;
            oout_d  = cand_data_s;
            osel_d  = cand_idx_s;
            if (imode) begin
                if (int'(cand_idx_s) == NCH - 1) begin
                    ptr_d = {SW{1'b0}};
                end else begin
                    ptr_d = cand_idx_s + {{(SW-1){1'b0}}, 1'b1};
                end
            end else begin
                ptr_d = ptr_q;
            end
        end else if (slot_free_s) begin
            state_d = EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // Output register, state and round-robin pointer.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= EMPTY;
            oout_q  <= {DW{1'b0}};
            osel_q  <= {SW{1'b0}};
            ptr_q   <= {SW{1'b0}};
        end else begin
            state_q <= state_d;
            oout_q  <= oout_d;
            osel_q  <= osel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef PARA_MUX_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of downstream transfers.
    always_comb begin
        if ((state_q == FULL) && iready && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Transfer counter register.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ocnt = cnt_q;
`endif

    assign oready = oready_s;
    assign oout   = oout_q;
    assign osel   = osel_q;
    assign ovalid = (state_q == FULL);

endmodule
